execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide instructions. It sits in the EX stage beside the single-cycle ALU path and applies the same EX_MEM/MEM_WB operand forwarding. Unlike the single-cycle path, it iterates over several cycles. It uses a valid/ready handshake on both sides so the hazard unit can stall the pipeline, and it supports flush and early-out for special cases.

Parameters:
XLEN, 32, operand/result width (32 or 64)
UNROLL, 1, quotient/product bits resolved per iteration cycle; must divide XLEN (1, 2, 4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept; high only in IDLE
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  in  XLEN  register-file operand A
rs2_data  in  XLEN  register-file operand B
from_mem  in  XLEN  EX_MEM forwarded value
from_wb  in  XLEN  MEM_WB forwarded value
ctrl_forward_left_operand  in  forwarding_type  selects the source of A
ctrl_forward_right_operand  in  forwarding_type  selects the source of B
flush  in  1  abort the in-flight operation
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  result
busy  out  1  state != IDLE (stall request to hazard unit)

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, busy=0, in_ready=1 on the cycle after reset deasserts. Reset mid-operation discards all state.
- Forwarding is applied combinationally at accept only.
  - A = from_mem if EX_MEM, from_wb if MEM_WB, else rs1_data; B likewise with rs2_data.
  - Operands and funct3 are latched on accept (in_valid && in_ready && !flush) at cycle T.
- States and transitions:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept of a special case.
  - CALC -> DONE after N = XLEN/UNROLL iteration cycles.
  - DONE -> IDLE when out_ready.
- Latency: normal op out_valid at T+N+1 (XLEN=32, UNROLL=1: T+33); special case out_valid at T+1. Throughput is one op per N+2 cycles minimum; no accept in DONE.
- Multiply:
  - Form unsigned magnitudes with shift-add, UNROLL partial products per cycle, into a 2*XLEN product.
  - Negate the full product when the operand signs differ.
  - Signedness: MULH A,B signed; MULHSU A signed, B unsigned; MULHU/MUL unsigned magnitudes.
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, UNROLL quotient bits per cycle.
  - Quotient sign = sign(A) xor sign(B) for DIV. Remainder sign = sign(A) for REM. DIVU/REMU take no signs.
- Special cases (early-out, no CALC):
  - B=0: DIV/DIVU give all ones; REM/REMU give A.
  - DIV with A = most-negative and B = -1: quotient = A, REM = 0.
  - MUL* with either operand 0: result 0.
- Output handshake: out_valid held with result stable until out_ready; result unchanged while out_valid && !out_ready.
- Flush: highest priority.
  - Next cycle state IDLE, out_valid=0, busy=0; result keeps its last value.
  - Flush concurrent with in_valid in IDLE means no accept.
  - Flush in DONE drops the result even if out_ready is high.
- busy is asserted from T+1 through the cycle the result is consumed. The hazard unit stalls on (busy && !(out_valid && out_ready)).

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3), XLEN=32, UNROLL=1 -> result 0xFFFFFFEB at T+33; in_ready low T+1..T+33.
- MULH A=B=0x80000000 -> 0x40000000. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Repeat with UNROLL=4: out_valid at T+9.
- DIVU 5/0 -> 0xFFFFFFFF at T+1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Forwarding: rs1_data=1, from_mem=6, from_wb=9, left=EX_MEM, right=MEM_WB, MUL -> 54. Changing from_mem after accept has no effect.
- Flush at T+10 of a DIV -> out_valid never rises, in_ready=1 at T+11. Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable; reset asserted mid-CALC -> out_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/execute_muldiv.sv
// ---------------------------------------------------------------------------
// execute_muldiv
//
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage. Operands get
// the same EX_MEM / MEM_WB forwarding as the single-cycle ALU path, applied
// once when a request is accepted. The operation then iterates
// XLEN/UNROLL cycles (shift-add multiply or restoring divide on unsigned
// magnitudes). Trivial cases (divide by zero, signed overflow, multiply by
// zero) skip the iteration and are answered on the next cycle.
//
// Parameters:
//   XLEN    operand/result width (32 or 64)
//   UNROLL  bits resolved per iteration cycle; must divide XLEN (1, 2, 4)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         request handshake (ready only while idle)
//   funct3                      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                               100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_data, rs2_data          register-file operands
//   from_mem, from_wb           EX_MEM and MEM_WB forwarded values
//   ctrl_forward_left_operand   source of A: 00 register, 01 EX_MEM, 10 MEM_WB
//   ctrl_forward_right_operand  source of B, same encoding
//   flush                       abort whatever is in flight (highest priority)
//   out_valid / out_ready       result handshake
//   result                      registered result, held until consumed
//   busy                        unit occupied; used by the hazard unit to stall
// ---------------------------------------------------------------------------
module execute_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] from_mem,
  input  logic [XLEN-1:0] from_wb,
  input  logic [1:0]      ctrl_forward_left_operand,
  input  logic [1:0]      ctrl_forward_right_operand,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int N = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  op_a, op_b, mag_a, mag_b, special_result;
  logic             op_is_div, a_signed, b_signed, sign_a, sign_b;
  logic             negate_in, special, accept;

  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_q, hi_q, lo_q, result_q;
  logic             negate_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0]   hi_n, lo_n, quot_s, rem_s, final_result;
  logic [XLEN:0]     rem_t, sum_t;
  logic [2*XLEN-1:0] prod, prod_s;

  // Operand forwarding. Only meaningful in the accept cycle; afterwards the
  // latched magnitudes are used, so later changes on the bypass buses are
  // ignored.
  always_comb begin
    op_a = rs1_data;
    op_b = rs2_data;
    case (ctrl_forward_left_operand)
      FWD_EX_MEM: op_a = from_mem;
      FWD_MEM_WB: op_a = from_wb;
      default:    op_a = rs1_data;
    endcase
    case (ctrl_forward_right_operand)
      FWD_EX_MEM: op_b = from_mem;
      FWD_MEM_WB: op_b = from_wb;
      default:    op_b = rs2_data;
    endcase
  end

  // Decode the request: which operands are signed, the unsigned magnitudes
  // the datapath works on, whether the final value must be negated, and the
  // early-out cases whose answer is known without iterating. MUL only needs
  // the low half, which is the same for signed and unsigned inputs, so it is
  // handled as unsigned. Negating the most negative value yields the same bit
  // pattern, which is its correct unsigned magnitude.
  always_comb begin
    op_is_div = funct3[2];
    a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a    = a_signed && op_a[XLEN-1];
    sign_b    = b_signed && op_b[XLEN-1];
    mag_a     = sign_a ? -op_a : op_a;
    mag_b     = sign_b ? -op_b : op_b;
    negate_in = (op_is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
    special        = 1'b0;
    special_result = '0;
    if (op_is_div) begin
      if (op_b == '0) begin
        special        = 1'b1;
        special_result = funct3[1] ? op_a : '1;
      end else if (!funct3[0] && (op_a == MOST_NEG) && (op_b == '1)) begin
        special        = 1'b1;
        special_result = funct3[1] ? '0 : op_a;
      end
    end else if ((op_a == '0) || (op_b == '0)) begin
      special        = 1'b1;
      special_result = '0;
    end
  end

  assign accept = in_valid && in_ready && !flush;

  // One iteration cycle, UNROLL steps deep. Divide: hi holds the partial
  // remainder, lo shifts the dividend out and the quotient in. Multiply:
  // hi accumulates, lo shifts the multiplier out and the low product in;
  // after N cycles {hi, lo} is the full 2*XLEN product.
  always_comb begin
    hi_n  = hi_q;
    lo_n  = lo_q;
    rem_t = '0;
    sum_t = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        rem_t = {hi_n, lo_n[XLEN-1]};
        lo_n  = {lo_n[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, a_q}) begin
          rem_t   = rem_t - {1'b0, a_q};
          lo_n[0] = 1'b1;
        end
        hi_n = rem_t[XLEN-1:0];
      end else begin
        sum_t = {1'b0, hi_n} + (lo_n[0] ? {1'b0, a_q} : '0);
        lo_n  = {sum_t[0], lo_n[XLEN-1:1]};
        hi_n  = sum_t[XLEN:1];
      end
    end
  end

  // Sign fix-up and result selection, applied to the values produced by the
  // last iteration so the answer can be registered on the same edge that
  // enters DONE.
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = negate_q ? -prod : prod;
    quot_s = negate_q ? -lo_n : lo_n;
    rem_s  = negate_q ? -hi_n : hi_n;
    if (op_q[2]) begin
      final_result = op_q[1] ? rem_s : quot_s;
    end else begin
      final_result = (op_q[1:0] != 2'b00) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  // Next-state logic. Flush overrides everything, including a result that is
  // being consumed in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == LAST_ITER) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State and datapath registers. Operands are captured as magnitudes on
  // accept (a_q is the multiplicand or the divisor). The result register is
  // only written when an answer is produced, so it holds its value across
  // flushes and while waiting for out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      negate_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= funct3;
        a_q      <= op_is_div ? mag_b : mag_a;
        hi_q     <= '0;
        lo_q     <= op_is_div ? mag_a : mag_b;
        negate_q <= negate_in;
        cnt_q    <= '0;
        if (special) result_q <= special_result;
      end else if ((state_q == CALC) && !flush) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) result_q <= final_result;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// ---------------------------------------------------------------------------
// tb_execute_muldiv
//
// Bench for execute_muldiv. Two instances share every input: u1 iterates one
// bit per cycle, u4 four bits per cycle, so each request exercises both
// latencies. Table vectors are driven one at a time, their expected result
// and latencies pushed to a scoreboard, and popped when the outputs appear.
// Hand-written sequences cover back-pressure, flush and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_execute_muldiv;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam int NV = 27;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    bit          special;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat1;
    int          lat4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, from_mem, from_wb;
  logic [1:0]  ctrl_forward_left_operand, ctrl_forward_right_operand;
  logic        flush;
  logic        out_ready;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] result1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] result4;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];
  exp_t sb[$];

  execute_muldiv #(.XLEN(32), .UNROLL(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .from_mem(from_mem), .from_wb(from_wb),
    .ctrl_forward_left_operand(ctrl_forward_left_operand),
    .ctrl_forward_right_operand(ctrl_forward_right_operand),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .busy(busy1)
  );

  execute_muldiv #(.XLEN(32), .UNROLL(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .from_mem(from_mem), .from_wb(from_wb),
    .ctrl_forward_left_operand(ctrl_forward_left_operand),
    .ctrl_forward_right_operand(ctrl_forward_right_operand),
    .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .busy(busy4)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one request for a single accept cycle (caller guarantees the
  // units are idle, and calls this #1 after a rising edge), then scrambles
  // every operand input so the bench notices if the design keeps reading
  // them after accept.
  task automatic driveOp(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] m, input logic [31:0] w,
                         input logic [1:0] fls, input logic [1:0] frs);
    funct3 = f3;
    rs1_data = r1;
    rs2_data = r2;
    from_mem = m;
    from_wb = w;
    ctrl_forward_left_operand = fls;
    ctrl_forward_right_operand = frs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    funct3 = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    from_mem = $urandom;
    from_wb = $urandom;
    ctrl_forward_left_operand = 2'($urandom_range(0, 2));
    ctrl_forward_right_operand = 2'($urandom_range(0, 2));
  endtask

  // Drives a request and records what both instances must answer and when.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] m, input logic [31:0] w,
                               input logic [1:0] fls, input logic [1:0] frs,
                               input logic [31:0] exp_res, input bit special);
    exp_t e;
    e.res = exp_res;
    e.lat1 = special ? 1 : 33;
    e.lat4 = special ? 1 : 9;
    sb.push_back(e);
    driveOp(f3, r1, r2, m, w, fls, frs);
  endtask

  // Follows both instances from the cycle after accept until each raises
  // out_valid (bounded), checks the unit stalls the pipe while working,
  // then compares against the scoreboard and checks both return to idle.
  task automatic waitResult(input string name);
    int lat1 = -1;
    int lat4 = -1;
    logic [31:0] res1 = '0;
    logic [31:0] res4 = '0;
    bit stall_ok = 1'b1;
    exp_t e;
    for (int cyc = 1; cyc <= 100 && (lat1 < 0 || lat4 < 0); cyc++) begin
      if (lat1 < 0) begin
        if (out_valid1) begin
          lat1 = cyc;
          res1 = result1;
        end else if (in_ready1 || !busy1) begin
          stall_ok = 1'b0;
        end
      end
      if (lat4 < 0) begin
        if (out_valid4) begin
          lat4 = cyc;
          res4 = result4;
        end else if (in_ready4 || !busy4) begin
          stall_ok = 1'b0;
        end
      end
      if (lat1 < 0 || lat4 < 0) begin
        @(posedge clk);
        #1;
      end
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sb.pop_front();
      checkOutput({name, "_res_u1"}, 64'(res1), 64'(e.res));
      checkOutput({name, "_res_u4"}, 64'(res4), 64'(e.res));
      checkOutput({name, "_lat_u1"}, 64'(lat1), 64'(e.lat1));
      checkOutput({name, "_lat_u4"}, 64'(lat4), 64'(e.lat4));
      checkOutput({name, "_stall"}, 64'(stall_ok), 64'd1);
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_idle"}, 64'({busy1, busy4, out_valid1, out_valid4, in_ready1, in_ready4}),
                64'(6'b000011));
  endtask

  // Main sequence: reset, table vectors, forwarding, then the hand-written
  // multi-cycle corner cases.
  initial begin
    bit quiet;

    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        1'b1};
    vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{OP_MUL,    32'd0,        32'd5,        32'd0,        1'b1};
    vecs[13] = '{OP_MULH,   32'd3,        32'd0,        32'd0,        1'b1};
    vecs[14] = '{OP_MULHSU, 32'd2,        32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[15] = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[16] = '{OP_DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
    vecs[17] = '{OP_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[18] = '{OP_DIV,    32'd10,       32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0};
    vecs[19] = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
    vecs[20] = '{OP_DIVU,   32'h80000000, 32'd3,        32'h2AAAAAAA, 1'b0};
    vecs[21] = '{OP_REMU,   32'hFFFFFFFF, 32'd16,       32'd15,       1'b0};
    vecs[22] = '{OP_MULHU,  32'h80000000, 32'd2,        32'd1,        1'b0};
    vecs[23] = '{OP_DIVU,   32'd7,        32'd100,      32'd0,        1'b0};
    vecs[24] = '{OP_REMU,   32'd7,        32'd100,      32'd7,        1'b0};
    vecs[25] = '{OP_REMU,   32'd9,        32'd0,        32'd9,        1'b1};
    vecs[26] = '{OP_DIV,    32'd0,        32'd5,        32'd0,        1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    funct3 = '0;
    rs1_data = '0;
    rs2_data = '0;
    from_mem = '0;
    from_wb = '0;
    ctrl_forward_left_operand = FWD_NONE;
    ctrl_forward_right_operand = FWD_NONE;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_state_u1", 64'({out_valid1, busy1, in_ready1, result1}), 64'({3'b001, 32'h0}));
    checkOutput("reset_state_u4", 64'({out_valid4, busy4, in_ready4, result4}), 64'({3'b001, 32'h0}));

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b, 32'h0, 32'h0, FWD_NONE, FWD_NONE,
                    vecs[i].exp_res, vecs[i].special);
      waitResult($sformatf("vec%0d", i));
    end

    applyStimulus(OP_MUL, 32'd1, 32'd2, 32'd6, 32'd9, FWD_EX_MEM, FWD_MEM_WB, 32'd54, 1'b0);
    waitResult("fwd_mul");
    applyStimulus(OP_DIVU, 32'd3, 32'd3, 32'd7, 32'd100, FWD_MEM_WB, FWD_EX_MEM, 32'd14, 1'b0);
    waitResult("fwd_divu");

    out_ready = 1'b0;
    driveOp(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, FWD_NONE, FWD_NONE);
    for (int k = 0; k < 100 && !out_valid1; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold_reach", 64'(out_valid1), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold_u1_%0d", k), 64'({out_valid1, in_ready1, busy1, result1}),
                  64'({3'b101, 32'd14}));
      checkOutput($sformatf("hold_u4_%0d", k), 64'({out_valid4, in_ready4, result4}),
                  64'({2'b10, 32'd14}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hold_release", 64'({out_valid1, out_valid4, in_ready1, in_ready4, busy1}),
                64'(5'b00110));

    driveOp(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, FWD_NONE, FWD_NONE);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_calc_state", 64'({in_ready1, out_valid1, busy1}), 64'(3'b100));
    checkOutput("flush_calc_result_kept", 64'(result1), 64'd14);
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid1) quiet = 1'b0;
    end
    checkOutput("flush_calc_no_valid", 64'(quiet), 64'd1);

    funct3 = OP_MUL;
    rs1_data = 32'd3;
    rs2_data = 32'd0;
    ctrl_forward_left_operand = FWD_NONE;
    ctrl_forward_right_operand = FWD_NONE;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush_idle_no_accept", 64'({busy1, busy4, out_valid1, out_valid4, in_ready1, in_ready4}),
                64'(6'b000011));

    out_ready = 1'b0;
    driveOp(OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h0, FWD_NONE, FWD_NONE);
    checkOutput("flush_done_pre", 64'({out_valid1, result1}), 64'({1'b1, 32'hFFFFFFFF}));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b1;
    checkOutput("flush_done_drop", 64'({out_valid1, busy1, in_ready1, result1}),
                64'({3'b001, 32'hFFFFFFFF}));

    driveOp(OP_DIV, 32'd100, 32'd7, 32'h0, 32'h0, FWD_NONE, FWD_NONE);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_mid_calc_u1", 64'({out_valid1, busy1, in_ready1, result1}), 64'({3'b001, 32'h0}));
    checkOutput("reset_mid_calc_u4", 64'({out_valid4, busy4, in_ready4, result4}), 64'({3'b001, 32'h0}));

    applyStimulus(OP_REM, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, FWD_NONE, FWD_NONE, 32'hFFFFFFFF, 1'b0);
    waitResult("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
